div_unit: RTL and testbench
===========================

# div_unit

Iterative multi-cycle integer divider for the RV32 core's M-extension DIV/DIVU/REM/REMU, sitting beside the combinational `alu` in the execute stage. It performs radix-2 restoring division on operand pairs, one quotient bit per clock. A start/ready/valid handshake lets the single-cycle datapath stall while an operation is in flight. Division-by-zero results follow the RISC-V spec, and no trap is raised.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  request; accepted only on a rising edge where ready_o=1.
- flush_i  in  1  abort the in-flight operation; no valid_o is produced.
- div_op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept.
- operand_a_i  in  WIDTH  dividend; sampled at accept.
- operand_b_i  in  WIDTH  divisor; sampled at accept.
- ready_o  out  1  high only in IDLE.
- valid_o  out  1  one-cycle pulse; div_data_o is valid in that cycle.
- div_data_o  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accept or reset.

## Operation
- States: IDLE, BUSY, DONE.
- Reset values: state IDLE, ready_o=1, valid_o=0, div_data_o=0, iteration counter 0.
- IDLE to BUSY on `start_i & ready_o & ~flush_i`, when the divisor is non-zero. At this edge:
  - op, |a| and |b| are latched; DIVU/REMU use raw values.
  - Quotient sign = sign(a) XOR sign(b), for DIV only.
  - Remainder sign = sign(a), for REM only.
  - Partial remainder is cleared; counter is set to 0.
- IDLE to DONE on accept with operand_b_i==0 (fast path). At this edge div_data_o is written:
  - DIV/DIVU: all ones.
  - REM/REMU: operand_a_i unchanged.
- Each BUSY edge performs one iteration:
  - Shift {rem, quo} left by 1.
  - Trial subtract rem − |b| at WIDTH+1 bits.
  - If non-negative, rem = difference and quo LSB = 1; otherwise the shifted rem is kept and quo LSB = 0.
  - Counter increments.
- BUSY to DONE on the edge that completes iteration WIDTH-1 (counter==WIDTH-1). The same edge writes div_data_o with the sign-corrected quotient or remainder (two's-complement negate when the sign flag is set).
- DONE: valid_o=1 for exactly this cycle, ready_o=0. Next edge goes unconditionally to IDLE.
- Signed overflow (0x80000000 / 0xFFFFFFFF) takes the normal path with no special case:
  - |a| = 0x80000000 as unsigned, giving quotient 0x80000000 (negate is identity) and remainder 0.
- start_i in BUSY or DONE is ignored; it is not queued.
- flush_i in BUSY or DONE: next state IDLE, no valid_o, div_data_o keeps its previous value.
- Priority: rst_i > flush_i > start_i. A flush_i and start_i in the same IDLE cycle means the start is dropped.
- Reset mid-operation: the next cycle shows IDLE, ready_o=1, valid_o=0, div_data_o=0.

## Timing
- Cycle numbering: start_i high with ready_o=1 in cycle 0. The accept edge is the end of cycle 0.
- Normal path:
  - BUSY occupies cycles 1..WIDTH.
  - valid_o is high in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - ready_o is high again in cycle WIDTH+2.
- Divide-by-zero: valid_o high in cycle 1, ready_o high in cycle 2.
- Back-to-back: the earliest next accept is in the first cycle after DONE. Minimum issue interval is WIDTH+2 cycles (normal path) or 2 cycles (fast path).
- Outputs are registered or state-decoded; there is no combinational path from inputs to ready_o, valid_o or div_data_o.
- Critical path: one WIDTH+1-bit subtract plus mux per cycle. Sign fix-up adds one negate on the final edge.

## Test plan
- DIVU 100/7:
  - ready_o=0 in cycles 1..33.
  - valid_o=1 only in cycle 33 with div_data_o=14.
  - REMU on the same operands gives 2; div_data_o holds 2 after valid_o falls.
- Signed operands:
  - DIV −7/2 gives 0xFFFFFFFD; REM −7/2 gives 0xFFFFFFFF.
  - DIV 7/−2 gives 0xFFFFFFFD; REM 7/−2 gives 1.
- Overflow and extremes:
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM on the same gives 0.
  - DIVU 0xFFFFFFFF/1 gives 0xFFFFFFFF.
- Divide by zero:
  - DIVU 5/0 gives 0xFFFFFFFF; DIV −5/0 gives 0xFFFFFFFF; REM −5/0 gives 0xFFFFFFFB.
  - In each case valid_o is high in cycle 1 and ready_o in cycle 2.
- Abort paths:
  - rst_i in cycle 10 of BUSY: cycle 11 shows ready_o=1, valid_o=0, div_data_o=0, and no valid_o follows.
  - flush_i in cycle 10: same, but div_data_o keeps the prior result.
  - flush_i together with start_i in IDLE: no operation starts.
- Start while busy:
  - A second start_i pulse with different operands in cycle 5 is ignored; the first result (100/7=14) appears in cycle 33.
  - A new start in cycle 34 is accepted and produces its result in cycle 67.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero short-circuits to DONE.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [1:0]       div_op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] div_data_o
);

    localparam int unsigned   CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_BUSY = 2'd1;
    localparam logic [1:0]    S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_rem;
    logic             r_neg;
    logic [WIDTH-1:0] r_abs_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_data;

    logic             w_accept;
    logic             w_signed_op;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_result_fix;

    // Handshake outputs are decoded straight from the state register.
    assign ready_o    = (r_state == S_IDLE);
    assign valid_o    = (r_state == S_DONE);
    assign div_data_o = r_data;

    // Accept decode and operand magnitudes (DIV/REM are the signed ops).
    assign w_accept    = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_signed_op = ~div_op_i[0];
    assign w_abs_a     = (w_signed_op && operand_a_i[WIDTH-1]) ? (~operand_a_i + WIDTH'(1)) : operand_a_i;
    assign w_abs_b     = (w_signed_op && operand_b_i[WIDTH-1]) ? (~operand_b_i + WIDTH'(1)) : operand_b_i;

    // One restoring step plus final sign fix-up.
    always_comb begin
        w_shift_rem  = {r_rem, r_quo[WIDTH-1]};
        w_diff       = w_shift_rem - {1'b0, r_abs_b};
        w_rem_next   = w_diff[WIDTH] ? w_shift_rem[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_quo_next   = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
        w_result     = r_is_rem ? w_rem_next : w_quo_next;
        w_result_fix = r_neg ? (~w_result + WIDTH'(1)) : w_result;
    end

    // Next-state logic; flush beats start and aborts BUSY/DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (operand_b_i == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == LAST) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: latch operands at accept, iterate in BUSY, write result on the last step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_is_rem <= 1'b0;
            r_neg    <= 1'b0;
            r_abs_b  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_data   <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_abs_b  <= w_abs_b;
            r_is_rem <= div_op_i[1];
            r_neg    <= w_signed_op &
                        (div_op_i[1] ? operand_a_i[WIDTH-1]
                                     : (operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1]));
            if (operand_b_i == '0) begin
                r_data <= div_op_i[1] ? operand_a_i : '1;
            end
        end else if ((r_state == S_BUSY) && !flush_i) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
                r_data <= w_result_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed and random operations.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic [1:0]  div_op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] div_data_o;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .flush_i     (flush_i),
        .div_op_i    (div_op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .div_data_o  (div_data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V M-extension semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        r = op[1] ? (sa % sb) : (sa / sb);
        return r[31:0];
    endfunction

    // Monitor: every valid_o pulse must match the oldest expectation, value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got valid_o=1 in cycle %0d, required 0", cyc);
            end else begin
                e = sb_q.pop_front();
                check("result_data", div_data_o, e.data);
                check("result_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Wait for ready (bounded), pulse start for one cycle; returns the cycle it was driven in.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] exp_data, output int c);
        int k = 0;
        while (!ready_o && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ready_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got ready_o=0 after %0d cycles, required 1", k);
        end
        start_i     = 1'b1;
        div_op_i    = op;
        operand_a_i = a;
        operand_b_i = b;
        c           = cyc;
        if (push) sb_q.push_back('{exp_data, cyc + ((b == 32'd0) ? 1 : 33)});
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Check ready_o/valid_o per cycle after an accept with the given latency.
    task automatic watch(input int lat);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            check("ready_o", 32'(ready_o), 32'(k == lat + 1));
            check("valid_o", 32'(valid_o), 32'(k == lat));
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int c, c2;
        logic [1:0]  op;
        logic [31:0] a, b;
        int          sel;

        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        div_op_i = 2'b00; operand_a_i = '0; operand_b_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_data", div_data_o, 32'd0);
        @(posedge clk); #1;

        // DIVU / REMU 100/7 with cycle-accurate handshake checks
        issue(2'b01, 32'd100, 32'd7, 1'b1, 32'd14, c);
        watch(33);
        issue(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, c);
        watch(33);
        @(negedge clk);
        check("remu_hold", div_data_o, 32'd2);
        @(posedge clk); #1;

        // Signed, overflow, extremes and divide-by-zero
        vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
        vecs.push_back('{2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
        vecs.push_back('{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF});
        vecs.push_back('{2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF});
        vecs.push_back('{2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB});
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].q, c);
            watch((vecs[i].b == 32'd0) ? 1 : 33);
        end

        // Reset during BUSY cycle 10
        issue(2'b01, 32'd100, 32'd7, 1'b0, 32'd0, c);
        repeat (9) begin @(posedge clk); #1; end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_abort_ready", 32'(ready_o), 32'd1);
        check("rst_abort_valid", 32'(valid_o), 32'd0);
        check("rst_abort_data", div_data_o, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        // Flush during BUSY cycle 10 keeps the previous result
        issue(2'b01, 32'd100, 32'd7, 1'b1, 32'd14, c);
        watch(33);
        issue(2'b01, 32'd200, 32'd3, 1'b0, 32'd0, c);
        repeat (9) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_abort_ready", 32'(ready_o), 32'd1);
        check("flush_abort_valid", 32'(valid_o), 32'd0);
        check("flush_abort_data", div_data_o, 32'd14);
        repeat (40) @(posedge clk);
        #1;

        // Flush together with start in IDLE drops the start
        start_i = 1'b1; flush_i = 1'b1;
        div_op_i = 2'b01; operand_a_i = 32'd9; operand_b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("flush_start_ready", 32'(ready_o), 32'd1);
        check("flush_start_data", div_data_o, 32'd14);
        repeat (40) @(posedge clk);
        #1;

        // Start while busy is ignored; restart in cycle 34 is accepted
        issue(2'b01, 32'd100, 32'd7, 1'b1, 32'd14, c);
        repeat (4) begin @(posedge clk); #1; end
        start_i = 1'b1; div_op_i = 2'b00; operand_a_i = 32'd1000; operand_b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (28) begin @(posedge clk); #1; end
        issue(2'b01, 32'd81, 32'd9, 1'b1, 32'd9, c2);
        check("restart_cycle", 32'(c2), 32'(c + 34));

        // Random back-to-back traffic
        for (int n = 0; n < 40; n++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(op, a, b, 1'b1, model(op, a, b), c);
        end

        // Drain outstanding results
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending results, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
